veda_memory: RTL and testbench

VEDA_MEMORY -- requirements
Module: veda_memory

---
 rtl/veda_memory.sv | 134 +++++++++++++
 tb/tb_veda_memory.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/veda_memory.sv
// Dual-port 32-bit word memory with self-clearing init sequence.
// Both ports are serviced every READY cycle; reads are registered and read-before-write.
module veda_memory #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        VEDA_mode1,
    input  logic [31:0] VEDA_address1,
    input  logic [31:0] VEDA_data_in1,
    output logic [31:0] VEDA_data_out1,

    input  logic        VEDA_mode2,
    input  logic [31:0] VEDA_address2,
    input  logic [31:0] VEDA_data_in2,
    output logic [31:0] VEDA_data_out2,

    output logic        ready,
    output logic        addr_err1,
    output logic        addr_err2
);

    // state    | meaning
    // ST_INIT  | clearing word[ptr_q] each cycle, ports ignored
    // ST_READY | both ports serviced every cycle
    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;

    logic [31:0]   mem_q [DEPTH];

    logic [31:0]   dout1_q, dout1_d;
    logic [31:0]   dout2_q, dout2_d;
    logic          err1_q, err1_d;
    logic          err2_q, err2_d;

    logic [AW-1:0] idx1, idx2;
    logic          oor1, oor2;
    logic          we1, we2;
    logic          svc;

    // Byte-offset bits [1:0] are dropped silently; any set bit above the
    // word index makes the request out of range.
    assign idx1 = VEDA_address1[AW+1:2];
    assign idx2 = VEDA_address2[AW+1:2];
    assign oor1 = |VEDA_address1[31:AW+2];
    assign oor2 = |VEDA_address2[31:AW+2];

    assign svc  = (state_q == ST_READY);
    assign we1  = svc && !VEDA_mode1 && !oor1;
    assign we2  = svc && !VEDA_mode2 && !oor2;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == ST_INIT) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == AW'(DEPTH - 1)) begin
                state_d = ST_READY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Outputs stay at their reset value of zero throughout INIT because INIT
    // is only ever entered through reset.
    always_comb begin
        dout1_d = dout1_q;
        dout2_d = dout2_q;
        err1_d  = 1'b0;
        err2_d  = 1'b0;
        if (svc) begin
            err1_d = oor1;
            err2_d = oor2;
            if (VEDA_mode1) begin
                dout1_d = oor1 ? 32'h0 : mem_q[idx1];
            end
            if (VEDA_mode2) begin
                dout2_d = oor2 ? 32'h0 : mem_q[idx2];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout1_q <= '0;
            dout2_q <= '0;
            err1_q  <= 1'b0;
            err2_q  <= 1'b0;
        end else begin
            dout1_q <= dout1_d;
            dout2_q <= dout2_d;
            err1_q  <= err1_d;
            err2_q  <= err2_d;
        end
    end

    // Storage has no reset; the INIT sweep provides the defined contents.
    // Port 2 is written last so it wins a same-word collision.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem_q[ptr_q] <= '0;
        end else begin
            if (we1) begin
                mem_q[idx1] <= VEDA_data_in1;
            end
            if (we2) begin
                mem_q[idx2] <= VEDA_data_in2;
            end
        end
    end

    assign ready          = svc;
    assign VEDA_data_out1 = dout1_q;
    assign VEDA_data_out2 = dout2_q;
    assign addr_err1      = err1_q;
    assign addr_err2      = err2_q;

endmodule

// File: tb/tb_veda_memory.sv
// Self-checking bench for veda_memory: directed scenarios plus random traffic
// compared against a word-array reference model.
module tb_veda_memory;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic        clk;
    logic        rst_n;
    logic        VEDA_mode1, VEDA_mode2;
    logic [31:0] VEDA_address1, VEDA_address2;
    logic [31:0] VEDA_data_in1, VEDA_data_in2;
    logic [31:0] VEDA_data_out1, VEDA_data_out2;
    logic        ready, addr_err1, addr_err2;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_m [DEPTH];
    logic [31:0] exp_out1, exp_out2;
    logic        exp_err1, exp_err2;
    logic        model_ready;

    veda_memory #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .VEDA_mode1    (VEDA_mode1),
        .VEDA_address1 (VEDA_address1),
        .VEDA_data_in1 (VEDA_data_in1),
        .VEDA_data_out1(VEDA_data_out1),
        .VEDA_mode2    (VEDA_mode2),
        .VEDA_address2 (VEDA_address2),
        .VEDA_data_in2 (VEDA_data_in2),
        .VEDA_data_out2(VEDA_data_out2),
        .ready         (ready),
        .addr_err1     (addr_err1),
        .addr_err2     (addr_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a word is addressed by byte address / 4; anything at or
    // beyond DEPTH*4 bytes is out of range.
    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
        exp_out1 = 32'h0;
        exp_out2 = 32'h0;
        exp_err1 = 1'b0;
        exp_err2 = 1'b0;
    endfunction

    function automatic void model_step(input logic m1, input logic [31:0] a1, input logic [31:0] d1,
                                       input logic m2, input logic [31:0] a2, input logic [31:0] d2);
        bit in1, in2;
        if (!model_ready) return;
        in1 = (a1 < 32'(DEPTH * 4));
        in2 = (a2 < 32'(DEPTH * 4));
        exp_err1 = !in1;
        exp_err2 = !in2;
        if (m1) exp_out1 = in1 ? mem_m[a1 / 4] : 32'h0;
        if (m2) exp_out2 = in2 ? mem_m[a2 / 4] : 32'h0;
        if (!m1 && in1) mem_m[a1 / 4] = d1;
        if (!m2 && in2) mem_m[a2 / 4] = d2;
    endfunction

    // Called at a negedge; returns at the following negedge.
    task automatic drive(input logic m1, input logic [31:0] a1, input logic [31:0] d1,
                         input logic m2, input logic [31:0] a2, input logic [31:0] d2);
        VEDA_mode1    = m1;
        VEDA_address1 = a1;
        VEDA_data_in1 = d1;
        VEDA_mode2    = m2;
        VEDA_address2 = a2;
        VEDA_data_in2 = d2;
        @(posedge clk);
        model_step(m1, a1, d1, m2, a2, d2);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_ready = 1'b0;
        VEDA_mode1 = 1'b1; VEDA_address1 = 32'h0; VEDA_data_in1 = 32'h0;
        VEDA_mode2 = 1'b1; VEDA_address2 = 32'h0; VEDA_data_in2 = 32'h0;
        #3;
        checks++;
        if (ready !== 1'b0 || VEDA_data_out1 !== 32'h0 || VEDA_data_out2 !== 32'h0 ||
            addr_err1 !== 1'b0 || addr_err2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b out1=%h out2=%h err1=%b err2=%b, required all zero",
                     ready, VEDA_data_out1, VEDA_data_out2, addr_err1, addr_err2);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            // Port 2 throws junk at the memory during INIT; it must be ignored.
            VEDA_mode2    = 1'b0;
            VEDA_address2 = (k % 2 == 0) ? 32'h4 : 32'h400;
            VEDA_data_in2 = 32'hFFFF_FFFF;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (ready !== (k == DEPTH)) begin
                errors++;
                $display("FAIL init_ready edge %0d: ready=%b required %b", k, ready, (k == DEPTH));
            end
            checks++;
            if (VEDA_data_out1 !== 32'h0 || addr_err1 !== 1'b0 || addr_err2 !== 1'b0) begin
                errors++;
                $display("FAIL init_outputs edge %0d: out1=%h err1=%b err2=%b required 0",
                         k, VEDA_data_out1, addr_err1, addr_err2);
            end
        end
        model_ready = 1'b1;
        model_clear();
        drive(1'b1, 32'h0, 32'h0, 1'b1, 32'h4, 32'h0);
        checks++;
        if (VEDA_data_out1 !== 32'h0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL first_read: out1=%h ready=%b required 0 and 1", VEDA_data_out1, ready);
        end
        checks++;
        if (VEDA_data_out2 !== 32'h0) begin
            errors++;
            $display("FAIL init_write_ignored: out2=%h required 00000000", VEDA_data_out2);
        end
    endtask

    task automatic test_write_read();
        drive(1'b1, 32'h0, 32'h0, 1'b0, 32'h10, 32'hDEAD_BEEF);
        checks++;
        if (VEDA_data_out2 !== 32'h0) begin
            errors++;
            $display("FAIL write_holds_out2: got %h required 00000000", VEDA_data_out2);
        end
        drive(1'b1, 32'h10, 32'h0, 1'b1, 32'h0, 32'h0);
        checks++;
        if (VEDA_data_out1 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_then_read: got %h required deadbeef", VEDA_data_out1);
        end
    endtask

    task automatic test_rbw();
        drive(1'b0, 32'h20, 32'h1111_1111, 1'b1, 32'h10, 32'h0);
        checks++;
        if (VEDA_data_out1 !== 32'hDEAD_BEEF || VEDA_data_out2 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_holds_out1: out1=%h out2=%h required deadbeef both",
                     VEDA_data_out1, VEDA_data_out2);
        end
        drive(1'b1, 32'h20, 32'h0, 1'b0, 32'h20, 32'h2222_2222);
        checks++;
        if (VEDA_data_out1 !== 32'h1111_1111) begin
            errors++;
            $display("FAIL read_before_write: got %h required 11111111", VEDA_data_out1);
        end
        drive(1'b1, 32'h20, 32'h0, 1'b1, 32'h23, 32'h0);
        checks++;
        if (VEDA_data_out1 !== 32'h2222_2222 || VEDA_data_out2 !== 32'h2222_2222) begin
            errors++;
            $display("FAIL read_after_write: out1=%h out2=%h required 22222222 both",
                     VEDA_data_out1, VEDA_data_out2);
        end
    endtask

    task automatic test_same_write();
        drive(1'b0, 32'h40, 32'hA, 1'b0, 32'h41, 32'hB);
        drive(1'b1, 32'h40, 32'h0, 1'b1, 32'h42, 32'h0);
        checks++;
        if (VEDA_data_out1 !== 32'hB || VEDA_data_out2 !== 32'hB) begin
            errors++;
            $display("FAIL dual_write_port2_wins: out1=%h out2=%h required 0000000b both",
                     VEDA_data_out1, VEDA_data_out2);
        end
    endtask

    task automatic test_addr_err();
        drive(1'b0, 32'h0, 32'h5A5A_0F0F, 1'b1, 32'h40, 32'h0);
        drive(1'b1, 32'h400, 32'h0, 1'b0, 32'h400, 32'hFFFF_FFFF);
        checks++;
        if (VEDA_data_out1 !== 32'h0 || addr_err1 !== 1'b1 || addr_err2 !== 1'b1) begin
            errors++;
            $display("FAIL oor_request: out1=%h err1=%b err2=%b required 0,1,1",
                     VEDA_data_out1, addr_err1, addr_err2);
        end
        drive(1'b1, 32'h0, 32'h0, 1'b1, 32'h3, 32'h0);
        checks++;
        if (addr_err1 !== 1'b0 || addr_err2 !== 1'b0) begin
            errors++;
            $display("FAIL err_one_cycle: err1=%b err2=%b required 0,0", addr_err1, addr_err2);
        end
        checks++;
        if (VEDA_data_out1 !== 32'h5A5A_0F0F || VEDA_data_out2 !== 32'h5A5A_0F0F) begin
            errors++;
            $display("FAIL oor_write_discarded: out1=%h out2=%h required 5a5a0f0f both",
                     VEDA_data_out1, VEDA_data_out2);
        end
    endtask

    task automatic test_random();
        logic        m1, m2;
        logic [31:0] a1, a2, d1, d2;
        for (int n = 0; n < 400; n++) begin
            m1 = 1'($urandom_range(0, 1));
            m2 = 1'($urandom_range(0, 1));
            a1 = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            a2 = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a1 = a1 | (32'h1 << $urandom_range(31, AW + 2));
            if ($urandom_range(0, 7) == 0) a2 = a2 | (32'h1 << $urandom_range(31, AW + 2));
            if ($urandom_range(0, 15) == 0) a1 = 32'((DEPTH - 1) * 4);
            d1 = $urandom;
            d2 = $urandom;
            drive(m1, a1, d1, m2, a2, d2);
            checks++;
            if (VEDA_data_out1 !== exp_out1 || addr_err1 !== exp_err1) begin
                errors++;
                $display("FAIL random_port1 step %0d: out1=%h err1=%b required %h %b",
                         n, VEDA_data_out1, addr_err1, exp_out1, exp_err1);
            end
            checks++;
            if (VEDA_data_out2 !== exp_out2 || addr_err2 !== exp_err2 || ready !== 1'b1) begin
                errors++;
                $display("FAIL random_port2 step %0d: out2=%h err2=%b ready=%b required %h %b 1",
                         n, VEDA_data_out2, addr_err2, ready, exp_out2, exp_err2);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 32'h8, 32'h1234_5678, 1'b0, 32'h404, 32'h0);
        drive(1'b1, 32'h8, 32'h0, 1'b1, 32'h400, 32'h0);
        checks++;
        if (VEDA_data_out1 !== 32'h1234_5678 || addr_err2 !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state: out1=%h err2=%b required 12345678 1",
                     VEDA_data_out1, addr_err2);
        end
        #1 rst_n = 1'b0;
        model_ready = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0 || VEDA_data_out1 !== 32'h0 || VEDA_data_out2 !== 32'h0 ||
            addr_err1 !== 1'b0 || addr_err2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: ready=%b out1=%h out2=%h err2=%b required all zero",
                     ready, VEDA_data_out1, VEDA_data_out2, addr_err2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        VEDA_mode1 = 1'b1; VEDA_address1 = 32'h8;
        VEDA_mode2 = 1'b1; VEDA_address2 = 32'h8;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_init_ready: got %b required 0", ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0 || VEDA_data_out1 !== 32'h0 || addr_err1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_init: ready=%b out1=%h err1=%b required zero",
                     ready, VEDA_data_out1, addr_err1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (ready !== (k == DEPTH)) begin
                errors++;
                $display("FAIL reinit_ready edge %0d: ready=%b required %b", k, ready, (k == DEPTH));
            end
        end
        model_ready = 1'b1;
        model_clear();
        drive(1'b1, 32'h8, 32'h0, 1'b1, 32'h40, 32'h0);
        checks++;
        if (VEDA_data_out1 !== 32'h0 || VEDA_data_out2 !== 32'h0) begin
            errors++;
            $display("FAIL reinit_cleared: out1=%h out2=%h required 0 both",
                     VEDA_data_out1, VEDA_data_out2);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_rbw();
        test_same_write();
        test_addr_err();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
